// File: rtl/clk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_ctrl_pkg
// Description : Shared types for the core clock-enable / reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_STEP  = 2'd0,
        MODE_SLOW  = 2'd1,
        MODE_FAST  = 2'd2,
        MODE_BURST = 2'd3
    } ce_mode_t;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BURST = 2'd3
    } ce_state_t;

    // Free-running modes start ticking immediately; the others wait for a press.
    function automatic ce_state_t entry_state(input ce_mode_t m);
        return ((m == MODE_SLOW) || (m == MODE_FAST)) ? ST_RUN : ST_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Two-flop synchroniser, stability counter and press-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any agreement in between restarts the stability window.
    always_comb begin
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/core_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_clock_ctrl
// Description : CPU clock-enable and stretched-reset sequencer (step/slow/fast/burst).
// Revision    : 1.0 - initial release
// ============================================================================
module core_clock_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int RST_CYCLES      = 2**24,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DIV_W           = 24,
    parameter int BURST_W         = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               step_n_i,
    input  logic [1:0]         mode_i,
    input  logic [DIV_W-1:0]   slow_div_i,
    input  logic [DIV_W-1:0]   fast_div_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic               halt_i,
    output logic               core_rst_o,
    output logic               core_ce_o,
    output logic               running_o,
    output logic [31:0]        tick_count_o
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    ce_state_t          state_q, state_d;
    ce_mode_t           mode_q, mode_d;
    ce_mode_t           mode_in;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               core_ce_q, core_ce_d;
    logic               core_rst_q, core_rst_d;
    logic [31:0]        tick_q, tick_d;
    logic [DIV_W-1:0]   sel_div;
    logic               div_hit;
    logic               press;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_n_i (step_n_i),
        .press_o (press)
    );

    assign mode_in = ce_mode_t'(mode_i);
    assign sel_div = (mode_q == MODE_SLOW) ? slow_div_i : fast_div_i;
    // >= rather than == so a divider lowered below the current count fires at once.
    assign div_hit = (div_q >= sel_div);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        hold_d     = hold_q;
        div_d      = div_q;
        burst_d    = burst_q;
        core_ce_d  = 1'b0;
        core_rst_d = core_rst_q;
        tick_d     = core_rst_q ? 32'd0 : (tick_q + 32'(core_ce_q));

        if (state_q == ST_HOLD) begin
            mode_d = mode_in;
            if (hold_q == HOLD_LAST) begin
                core_rst_d = 1'b0;
                hold_d     = '0;
                state_d    = entry_state(mode_in);
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end else if (mode_in != mode_q) begin
            mode_d  = mode_in;
            div_d   = '0;
            burst_d = '0;
            state_d = entry_state(mode_in);
        end else if (!halt_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (press) begin
                        if (mode_q == MODE_STEP) begin
                            core_ce_d = 1'b1;
                        end else if ((mode_q == MODE_BURST) && (burst_len_i != '0)) begin
                            burst_d = burst_len_i;
                            div_d   = '0;
                            state_d = ST_BURST;
                        end
                    end
                end
                ST_RUN: begin
                    if (div_hit) begin
                        core_ce_d = 1'b1;
                        div_d     = '0;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                ST_BURST: begin
                    if (div_hit) begin
                        core_ce_d = 1'b1;
                        div_d     = '0;
                        burst_d   = burst_q - 1'b1;
                        if (burst_q == BURST_W'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: state_d = ST_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_HOLD;
            mode_q     <= MODE_STEP;
            hold_q     <= '0;
            div_q      <= '0;
            burst_q    <= '0;
            core_ce_q  <= 1'b0;
            core_rst_q <= 1'b1;
            tick_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            hold_q     <= hold_d;
            div_q      <= div_d;
            burst_q    <= burst_d;
            core_ce_q  <= core_ce_d;
            core_rst_q <= core_rst_d;
            tick_q     <= tick_d;
        end
    end

    assign core_rst_o   = core_rst_q;
    assign core_ce_o    = core_ce_q;
    assign running_o    = (state_q == ST_RUN) || (state_q == ST_BURST);
    assign tick_count_o = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_core_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_clock_ctrl
// Description : Directed + randomised self-checking bench for core_clock_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_clock_ctrl;

    localparam int RST_CYCLES = 16;
    localparam int DEB        = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_n = 1'b1;
    logic        halt = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  slow_div = 8'd0;
    logic [7:0]  fast_div = 8'd0;
    logic [7:0]  burst_len = 8'd0;
    logic        core_rst, core_ce, running;
    logic [31:0] tick_count;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int run_cnt  = 0;
    int ce_hist[$];

    always #5 clk = ~clk;

    core_clock_ctrl #(
        .RST_CYCLES      (RST_CYCLES),
        .DEBOUNCE_CYCLES (DEB),
        .DIV_W           (8),
        .BURST_W         (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .step_n_i     (step_n),
        .mode_i       (mode),
        .slow_div_i   (slow_div),
        .fast_div_i   (fast_div),
        .burst_len_i  (burst_len),
        .halt_i       (halt),
        .core_rst_o   (core_rst),
        .core_ce_o    (core_ce),
        .running_o    (running),
        .tick_count_o (tick_count)
    );

    // One clock cycle; outputs are observed on the falling edge.
    task automatic cyc1();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (core_ce === 1'b1) ce_hist.push_back(cyc);
        if (running === 1'b1) run_cnt++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc1();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input int lo, input int hi);
        step_n = 1'b0;
        cycles(lo);
        step_n = 1'b1;
        cycles(hi);
    endtask

    task automatic wait_ce(input string tag, input int budget, output int n);
        n = 0;
        do begin
            cyc1();
            n++;
        end while ((core_ce !== 1'b1) && (n < budget));
        chk({tag, "_seen"}, {31'd0, core_ce}, 32'd1);
    endtask

    task automatic measure_hold(input string tag);
        int len;
        int bad;
        len = 0;
        bad = 0;
        while ((core_rst === 1'b1) && (len < 40)) begin
            len++;
            if ((core_ce !== 1'b0) || (tick_count !== 32'd0)) bad++;
            cyc1();
        end
        chk({tag, "_len"}, len, RST_CYCLES);
        chk({tag, "_quiet"}, bad, 0);
    endtask

    // Spacing between consecutive recorded pulses from index 'first' onward.
    function automatic int gap_errors(input int first, input int want);
        int e;
        e = 0;
        for (int i = first + 1; i < ce_hist.size(); i++)
            if (ce_hist[i] - ce_hist[i-1] != want) e++;
        return e;
    endfunction

    initial begin
        int n, base, r0, exp_tick, bad, m, d, k_len, cnt, bl, fd;
        int starts[3];
        logic exp_ce;
        exp_tick = 0;

        // ---------------- reset and hold ----------------
        cycles(3);
        chk("rst_core_rst", {31'd0, core_rst}, 1);
        chk("rst_ce", {31'd0, core_ce}, 0);
        chk("rst_running", {31'd0, running}, 0);
        chk("rst_tick", tick_count, 0);
        rst = 1'b0;
        measure_hold("hold1");
        chk("post_hold_running", {31'd0, running}, 0);

        // ---------------- STEP ----------------
        base = ce_hist.size();
        for (int p = 0; p < 3; p++) begin
            starts[p] = cyc;
            press(8, 10);
        end
        for (int g = 0; g < 3; g++) begin
            step_n = 1'b0; cycles(2);
            step_n = 1'b1; cycles(2);
        end
        cycles(10);
        chk("step_count", ce_hist.size() - base, 3);
        if (ce_hist.size() - base == 3) begin
            bad = 0;
            for (int p = 0; p < 3; p++) begin
                n = ce_hist[base+p] - starts[p];
                if ((n < 2 + DEB) || (n > 2 + DEB + 2)) bad++;
            end
            chk("step_latency", bad, 0);
            chk("step_width", gap_errors(base, 18), 0);
        end
        exp_tick = 3;
        chk("step_tick", tick_count, exp_tick);

        // ---------------- FAST ----------------
        fast_div = 8'd3;
        mode = 2'd2;
        wait_ce("fast_first", 20, n);
        chk("fast_first_lat", n, 5);
        chk("fast_running", {31'd0, running}, 1);
        for (int i = 0; i < 3; i++) begin
            wait_ce("fast_per", 20, n);
            chk("fast_period", n, 4);
        end
        exp_tick += 4;
        cycles(2);
        fast_div = 8'd1;
        wait_ce("fast_lower", 20, n);
        chk("fast_lower_lat", n, 1);
        for (int i = 0; i < 2; i++) begin
            wait_ce("fast_per2", 20, n);
            chk("fast_period2", n, 2);
        end
        fast_div = 8'd0;
        wait_ce("fast_div0", 20, n);
        chk("fast_div0_lat", n, 1);
        exp_tick += 4;
        mode = 2'd0;
        cyc1();
        chk("switch_ce_stop", {31'd0, core_ce}, 0);
        chk("switch_running", {31'd0, running}, 0);
        base = ce_hist.size();
        cycles(10);
        chk("switch_no_ce", ce_hist.size() - base, 0);
        chk("switch_tick", tick_count, exp_tick);

        // ---------------- randomised SLOW/FAST ----------------
        for (int r = 0; r < 6; r++) begin
            m = $urandom_range(1, 2);
            d = $urandom_range(0, 6);
            mode = 2'd0;
            cycles(2);
            if (m == 1) slow_div = 8'(d); else fast_div = 8'(d);
            mode = 2'(m);
            k_len = 3 * (d + 1) + d + 2;
            cnt = 0;
            for (int k = 1; k <= k_len; k++) begin
                cyc1();
                exp_ce = (k >= d + 2) && (((k - d - 2) % (d + 1)) == 0);
                if (exp_ce) cnt++;
                chk("rand_run_ce", {31'd0, core_ce}, {31'd0, exp_ce});
            end
            chk("rand_running", {31'd0, running}, 1);
            exp_tick += cnt;
        end
        mode = 2'd0;
        cycles(2);
        chk("rand_tick", tick_count, exp_tick);

        // ---------------- halt in SLOW ----------------
        slow_div = 8'd9;
        mode = 2'd1;
        wait_ce("slow_first", 30, n);
        chk("slow_first_lat", n, 11);
        cycles(4);
        halt = 1'b1;
        base = ce_hist.size();
        cycles(20);
        chk("halt_no_ce", ce_hist.size() - base, 0);
        halt = 1'b0;
        wait_ce("halt_resume", 30, n);
        chk("halt_resume_lat", n, 6);
        wait_ce("slow_period", 30, n);
        chk("slow_period_len", n, 10);
        exp_tick += 3;

        // ---------------- BURST ----------------
        mode = 2'd3;
        cycles(2);
        chk("burst_idle_running", {31'd0, running}, 0);

        burst_len = 8'd5;
        fast_div  = 8'd0;
        base = ce_hist.size();
        r0 = run_cnt;
        press(8, 10);
        cycles(10);
        chk("burst5_count", ce_hist.size() - base, 5);
        chk("burst5_back_to_back", gap_errors(base, 1), 0);
        chk("burst5_running", run_cnt - r0, 5);
        chk("burst5_idle", {31'd0, running}, 0);
        exp_tick += 5;

        fast_div = 8'd4;
        base = ce_hist.size();
        press(6, 6);
        press(6, 6);
        cycles(30);
        chk("burst_repress_count", ce_hist.size() - base, 5);
        chk("burst_repress_gap", gap_errors(base, 5), 0);
        exp_tick += 5;

        burst_len = 8'd0;
        base = ce_hist.size();
        r0 = run_cnt;
        press(8, 10);
        cycles(5);
        chk("burst0_count", ce_hist.size() - base, 0);
        chk("burst0_running", run_cnt - r0, 0);

        for (int r = 0; r < 2; r++) begin
            bl = $urandom_range(1, 6);
            fd = $urandom_range(0, 3);
            burst_len = 8'(bl);
            fast_div  = 8'(fd);
            base = ce_hist.size();
            press(8, 4);
            cycles(bl * (fd + 1) + 10);
            chk("rand_burst_count", ce_hist.size() - base, bl);
            chk("rand_burst_gap", gap_errors(base, fd + 1), 0);
            exp_tick += bl;
        end
        chk("burst_tick", tick_count, exp_tick);

        // ---------------- rst during BURST ----------------
        burst_len = 8'd40;
        fast_div  = 8'd0;
        press(8, 0);
        n = 0;
        while ((core_ce !== 1'b1) && (n < 10)) begin
            cyc1();
            n++;
        end
        chk("burst_active", {31'd0, core_ce}, 1);
        rst = 1'b1;
        cyc1();
        chk("midrst_ce", {31'd0, core_ce}, 0);
        chk("midrst_core_rst", {31'd0, core_rst}, 1);
        chk("midrst_running", {31'd0, running}, 0);
        chk("midrst_tick", tick_count, 0);
        cyc1();
        rst = 1'b0;
        measure_hold("hold2");
        cycles(3);
        chk("post_rst_tick", tick_count, 0);
        chk("post_rst_running", {31'd0, running}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
